dmd_frame_buffer: RTL and testbench

// Parametrised per-pattern photon-count frame buffer for single-pixel imaging. Captures one

---
 rtl/dmd_frame_buffer_if.sv | 23 ++
 rtl/dmd_frame_buffer.sv | 125 ++++++++++++
 tb/tb_dmd_frame_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmd_frame_buffer_if.sv
// rtl/dmd_frame_buffer_if.sv - drained-sample stream between frame buffer and host-link serialiser
interface dmd_frame_buffer_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_last;

    modport master (
        output out_valid,
        output data_out,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  data_out,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/dmd_frame_buffer.sv
// rtl/dmd_frame_buffer.sv - per-pattern photon-count frame buffer; optional DMD_SYNC_EN synchronises DMD_sig
module dmd_frame_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              RD,
    input  logic              start,
    input  logic [ADDR_W:0]   frame_len,
    input  logic              DMD_sig,
    input  logic [DATA_W-1:0] data_in,
    dmd_frame_buffer_if.master stream,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [ADDR_W:0]   wr_count
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W:0]   len, rd_addr, wr_cnt;
    logic              rd_issue, valid_q, last_q, done_q, overrun_q;
    logic [DATA_W-1:0] data_q;
    logic              dmd_s, dmd_q, dmd_edge;
    logic              arm, cap_wr, cap_last, xfer;

`ifdef DMD_SYNC_EN
    logic [1:0] dmd_sync;
    // Reset high so a trigger already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge RD) begin
        if (!RD) dmd_sync <= 2'b11;
        else     dmd_sync <= {dmd_sync[0], DMD_sig};
    end
    assign dmd_s = dmd_sync[1];
`else
    assign dmd_s = DMD_sig;
`endif

    always_ff @(posedge clk or negedge RD) begin
        if (!RD) dmd_q <= 1'b1;
        else     dmd_q <= dmd_s;
    end

    assign dmd_edge = dmd_s & ~dmd_q;
    assign arm      = (state == S_IDLE) && start && (frame_len != '0);
    assign cap_wr   = (state == S_CAPTURE) && dmd_edge;
    assign cap_last = cap_wr && ((wr_cnt + ONE) == len);
    assign xfer     = (state == S_DRAIN) && valid_q && stream.out_ready;

    always_ff @(posedge clk or negedge RD) begin
        if (!RD) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (arm)              state_nx = S_CAPTURE;
            S_CAPTURE: if (cap_last)         state_nx = S_DRAIN;
            S_DRAIN:   if (xfer && last_q)   state_nx = S_IDLE;
            default:                         state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cap_wr) mem[wr_cnt[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge RD) begin
        if (!RD) begin
            len       <= '0;
            wr_cnt    <= '0;
            rd_addr   <= '0;
            rd_issue  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (arm) begin
                len       <= (frame_len > DEPTH) ? DEPTH : frame_len;
                wr_cnt    <= '0;
                overrun_q <= 1'b0;
            end
            if (cap_wr) wr_cnt <= wr_cnt + ONE;
            if (cap_last) begin
                rd_addr  <= '0;
                rd_issue <= 1'b1;
            end
            if ((state == S_DRAIN) && dmd_edge) overrun_q <= 1'b1;
            // One read in flight at a time: next address is fetched only after a transfer.
            if (state == S_DRAIN) begin
                if (rd_issue) begin
                    data_q   <= mem[rd_addr[ADDR_W-1:0]];
                    last_q   <= (rd_addr == (len - ONE));
                    valid_q  <= 1'b1;
                    rd_addr  <= rd_addr + ONE;
                    rd_issue <= 1'b0;
                end else if (xfer) begin
                    valid_q <= 1'b0;
                    if (last_q) begin
                        done_q <= 1'b1;
                        last_q <= 1'b0;
                    end else begin
                        rd_issue <= 1'b1;
                    end
                end
            end
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.data_out  = data_q;
    assign stream.out_last  = last_q;
    assign busy             = (state != S_IDLE);
    assign done             = done_q;
    assign overrun          = overrun_q;
    assign wr_count         = wr_cnt;
endmodule

// File: tb/tb_dmd_frame_buffer.sv
// tb/tb_dmd_frame_buffer.sv - directed scoreboard bench for dmd_frame_buffer
module tb_dmd_frame_buffer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              RD;
    logic              start;
    logic [ADDR_W:0]   frame_len;
    logic              DMD_sig;
    logic [DATA_W-1:0] data_in;
    logic              busy, done, overrun;
    logic [ADDR_W:0]   wr_count;

    int errors = 0;
    int checks = 0;
    logic [DATA_W:0] exp_q[$];

    dmd_frame_buffer_if #(.DATA_W(DATA_W)) s_if ();

    dmd_frame_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .RD        (RD),
        .start     (start),
        .frame_len (frame_len),
        .DMD_sig   (DMD_sig),
        .data_in   (data_in),
        .stream    (s_if.master),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic arm(input int n);
        frame_len = n[ADDR_W:0];
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit last, input bit expect_store);
        data_in = d;
        DMD_sig = 1'b1;
        tick();
        DMD_sig = 1'b0;
        repeat (3) tick();
        if (expect_store) exp_q.push_back({last, d});
    endtask

    task automatic drain(input int stall_idx);
        int n = 0;
        int guard = 0;
        bit fin = 0;
        logic [DATA_W:0] e;
        s_if.out_ready = 1'b1;
        while (!fin && guard < 20000) begin
            if (s_if.out_valid === 1'b1) begin
                e = exp_q[0];
                if (n == stall_idx) begin
                    s_if.out_ready = 1'b0;
                    repeat (5) begin
                        tick();
                        chk("stall_valid", {31'd0, s_if.out_valid}, 32'd1);
                        chk("stall_data", {16'd0, s_if.data_out}, {16'd0, e[DATA_W-1:0]});
                    end
                    s_if.out_ready = 1'b1;
                end
                chk("drain_data", {16'd0, s_if.data_out}, {16'd0, e[DATA_W-1:0]});
                chk("drain_last", {31'd0, s_if.out_last}, {31'd0, e[DATA_W]});
                void'(exp_q.pop_front());
                tick();
                n++;
                if (e[DATA_W]) begin
                    chk("done_pulse", {31'd0, done}, 32'd1);
                    chk("busy_fall", {31'd0, busy}, 32'd0);
                    chk("valid_drop", {31'd0, s_if.out_valid}, 32'd0);
                    tick();
                    chk("done_once", {31'd0, done}, 32'd0);
                    fin = 1;
                end
            end else begin
                tick();
            end
            guard++;
        end
        if (!fin) chk("drain_timeout", 32'd0, 32'd1);
        chk("queue_empty", exp_q.size(), 32'd0);
        s_if.out_ready = 1'b0;
    endtask

    initial begin
        RD = 1'b0;
        start = 1'b0;
        frame_len = '0;
        DMD_sig = 1'b1;
        data_in = '0;
        s_if.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, s_if.out_valid}, 32'd0);
        chk("rst_data", {16'd0, s_if.data_out}, 32'd0);
        chk("rst_last", {31'd0, s_if.out_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        RD = 1'b1;
        repeat (3) tick();
        chk("idle_wr_count", {21'd0, wr_count}, 32'd0);

        // Steady-high trigger during capture must not write.
        arm(1);
        chk("arm_busy", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        chk("steady_high_no_write", {21'd0, wr_count}, 32'd0);
        DMD_sig = 1'b0;
        tick();
        send(16'h0abc, 1, 1);
        chk("single_wr_count", {21'd0, wr_count}, 32'd1);
        drain(-1);

        // Basic four-sample frame.
        arm(4);
        send(16'h0011, 0, 1);
        send(16'h0022, 0, 1);
        send(16'h0033, 0, 1);
        send(16'h0044, 1, 1);
        chk("f4_wr_count", {21'd0, wr_count}, 32'd4);
        drain(-1);
        chk("f4_wr_count_hold", {21'd0, wr_count}, 32'd4);

        // Backpressure mid-drain.
        arm(3);
        send(16'h1234, 0, 1);
        send(16'h5678, 0, 1);
        send(16'h9abc, 1, 1);
        drain(1);

        // Overrun: edge during drain is dropped and flagged.
        arm(2);
        send(16'h0101, 0, 1);
        send(16'h0202, 1, 1);
        send(16'hdead, 0, 0);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        drain(-1);
        repeat (2) tick();
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // frame_len==0 is ignored and does not clear overrun.
        arm(0);
        tick();
        chk("len0_idle", {31'd0, busy}, 32'd0);
        chk("len0_overrun_kept", {31'd0, overrun}, 32'd1);
        arm(1);
        chk("start_clears_overrun", {31'd0, overrun}, 32'd0);
        send(16'h7777, 1, 1);
        drain(-1);

        // Oversized frame clamps to full RAM.
        arm(DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) send(16'(i * 7 + 16'h0100), (i == DEPTH - 1), 1);
        chk("depth_wr_count", {21'd0, wr_count}, DEPTH);
        chk("depth_busy", {31'd0, busy}, 32'd1);
        drain(-1);

        // Asynchronous reset mid-capture aborts without done.
        arm(4);
        send(16'h00aa, 0, 0);
        send(16'h00bb, 0, 0);
        chk("pre_rst_wr_count", {21'd0, wr_count}, 32'd2);
        #2 RD = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_wr_count", {21'd0, wr_count}, 32'd0);
        tick();
        RD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        arm(2);
        send(16'h0c0c, 0, 1);
        send(16'h0d0d, 1, 1);
        drain(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
